clock_set_controller: RTL and testbench

- User-interface sequencer that configures the DigitalClock block from three debounced push buttons: mode, inc and ok.
- Edits the time or the alarm in BCD HH:MM and drives the clock's load_time_n/load_alarm_n strobes and BCD set buses.
- Owns alarm enable and stop, so the clock core never sees raw buttons.

---
 rtl/clock_ctrl_pkg.sv | 26 ++
 rtl/bcd_time_add.sv | 38 +++
 rtl/clock_set_controller.sv | 140 ++++++++++++++
 tb/tb_clock_set_controller.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_ctrl_pkg.sv
// Shared encodings for the clock-setting sequencer: FSM states, blink-field
// codes, BCD limits and the BCD hours increment helper.
package clock_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_T_HR, S_T_MIN, S_A_HR, S_A_MIN, S_COMMIT_T, S_COMMIT_A, S_SNOOZE
  } state_t;

  localparam logic [1:0] FLD_NONE = 2'd0;
  localparam logic [1:0] FLD_HR   = 2'd1;
  localparam logic [1:0] FLD_MIN  = 2'd2;

  localparam int HR_MAX  = 23;
  localparam int MIN_MAX = 59;
  localparam logic [5:0] HR_MAX_BCD = {2'(HR_MAX / 10), 4'(HR_MAX % 10)};

  localparam logic STROBE_OFF = 1'b1;

  // hh = {tens[1:0], units[3:0]}; 23 wraps to 00
  function automatic logic [5:0] bcd_hr_inc(input logic [5:0] hh);
    if (hh == HR_MAX_BCD) return 6'h00;
    if (hh[3:0] == 4'd9)  return {hh[5:4] + 2'd1, 4'd0};
    return {hh[5:4], hh[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/bcd_time_add.sv
// Adds a 0..59 minute offset to a BCD HH:MM; the minute carry into hours
// (with 24h wrap) is applied only when cen_i is high.
module bcd_time_add
  import clock_ctrl_pkg::*;
(
  input  logic [1:0] h1_i,
  input  logic [3:0] h2_i,
  input  logic [3:0] m1_i,
  input  logic [3:0] m2_i,
  input  logic [5:0] off_i,
  input  logic       cen_i,
  output logic [1:0] h1_o,
  output logic [3:0] h2_o,
  output logic [3:0] m1_o,
  output logic [3:0] m2_o
);

  logic [6:0] w_min;
  logic [5:0] w_hr;
  logic       w_wrap;
  logic [2:0] w_mt;

  always_comb begin
    w_min  = 7'(m1_i) * 7'd10 + 7'(m2_i) + 7'(off_i);
    w_wrap = (w_min > 7'(MIN_MAX));
    if (w_wrap) w_min = w_min - 7'(MIN_MAX + 1);
    w_hr = 6'(h1_i) * 6'd10 + 6'(h2_i) + 6'(w_wrap & cen_i);
    if (w_hr > 6'(HR_MAX)) w_hr = w_hr - 6'(HR_MAX + 1);
    w_mt = '0;
    for (int k = 1; k < 6; k++)
      if (w_min >= 7'(k * 10)) w_mt = 3'(k);
    m1_o = {1'b0, w_mt};
    m2_o = 4'(w_min - 7'(w_mt) * 7'd10);
    h1_o = (w_hr >= 6'd20) ? 2'd2 : (w_hr >= 6'd10) ? 2'd1 : 2'd0;
    h2_o = 4'(w_hr - 6'(h1_o) * 6'd10);
  end

endmodule

// File: rtl/clock_set_controller.sv
// Button-driven time/alarm editor for the DigitalClock core.
// Optional snooze on mode-while-ringing: define CLOCK_SET_SNOOZE_EN.
module clock_set_controller
  import clock_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 60
`ifdef CLOCK_SET_SNOOZE_EN
  , parameter int SNOOZE_MIN = 5
`endif
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       mode_btn_i,
  input  logic       inc_btn_i,
  input  logic       ok_btn_i,
  input  logic [1:0] cur_h1_i,
  input  logic [3:0] cur_h2_i,
  input  logic [3:0] cur_m1_i,
  input  logic [3:0] cur_m2_i,
  input  logic       alarm_i,
  output logic [1:0] set_h1_o,
  output logic [3:0] set_h2_o,
  output logic [3:0] set_m1_o,
  output logic [3:0] set_m2_o,
  output logic       load_time_n_o,
  output logic       load_alarm_n_o,
  output logic       stop_alarm_n_o,
  output logic       alarm_on_n_o,
  output logic       editing_o,
  output logic [1:0] field_o
);

  state_t      r_state, w_state_nx;
  logic [13:0] r_edit, w_edit_nx, r_alarm, w_alarm_nx, w_cur, w_min_inc;
  logic [15:0] r_cnt, w_cnt_nx;
  logic        r_alarm_on_n, w_alarm_on_nx, r_stop_n, w_stop_nx;
  logic        w_ok, w_mode, w_inc, w_is_hr, w_is_min;

  assign w_cur = {cur_h1_i, cur_h2_i, cur_m1_i, cur_m2_i};

  // Minute increment: carry suppressed so hours pass through untouched.
  bcd_time_add u_min_inc (
    .h1_i(r_edit[13:12]), .h2_i(r_edit[11:8]), .m1_i(r_edit[7:4]), .m2_i(r_edit[3:0]),
    .off_i(6'd1), .cen_i(1'b0),
    .h1_o(w_min_inc[13:12]), .h2_o(w_min_inc[11:8]), .m1_o(w_min_inc[7:4]), .m2_o(w_min_inc[3:0])
  );

`ifdef CLOCK_SET_SNOOZE_EN
  logic [13:0] w_snz;
  bcd_time_add u_snooze (
    .h1_i(cur_h1_i), .h2_i(cur_h2_i), .m1_i(cur_m1_i), .m2_i(cur_m2_i),
    .off_i(6'(SNOOZE_MIN)), .cen_i(1'b1),
    .h1_o(w_snz[13:12]), .h2_o(w_snz[11:8]), .m1_o(w_snz[7:4]), .m2_o(w_snz[3:0])
  );
`endif

  assign w_is_hr  = (r_state == S_T_HR)  || (r_state == S_A_HR);
  assign w_is_min = (r_state == S_T_MIN) || (r_state == S_A_MIN);

  always_comb begin
    w_ok          = ok_btn_i;
    w_mode        = mode_btn_i & ~ok_btn_i;
    w_inc         = inc_btn_i & ~ok_btn_i & ~mode_btn_i;
    w_state_nx    = r_state;
    w_edit_nx     = r_edit;
    w_alarm_nx    = r_alarm;
    w_cnt_nx      = '0;
    w_alarm_on_nx = r_alarm_on_n;
    w_stop_nx     = STROBE_OFF;
    case (r_state)
      S_IDLE: begin
        if (w_ok) w_stop_nx = ~alarm_i;
`ifdef CLOCK_SET_SNOOZE_EN
        else if (w_mode && alarm_i) begin
          w_stop_nx  = 1'b0;
          w_edit_nx  = w_snz;
          w_state_nx = S_SNOOZE;
        end
`endif
        else if (w_mode) begin
          w_edit_nx  = w_cur;
          w_state_nx = S_T_HR;
        end
        else if (w_inc) w_alarm_on_nx = ~r_alarm_on_n;
      end
      S_T_HR, S_T_MIN, S_A_HR, S_A_MIN: begin
        if (w_ok)
          w_state_nx = (r_state == S_T_HR || r_state == S_T_MIN) ? S_COMMIT_T : S_COMMIT_A;
        else if (w_mode) begin
          case (r_state)
            S_T_HR:  w_state_nx = S_T_MIN;
            S_T_MIN: begin
              w_edit_nx  = r_alarm;
              w_state_nx = S_A_HR;
            end
            S_A_HR:  w_state_nx = S_A_MIN;
            default: w_state_nx = S_IDLE;
          endcase
        end
        else if (w_inc)
          w_edit_nx = w_is_hr ? {bcd_hr_inc(r_edit[13:8]), r_edit[7:0]} : w_min_inc;
        else if (r_cnt == 16'(TIMEOUT_CYCLES - 1)) w_state_nx = S_IDLE;
        else w_cnt_nx = r_cnt + 16'd1;
      end
      S_COMMIT_A: begin
        w_alarm_nx = r_edit;
        w_state_nx = S_IDLE;
      end
      S_SNOOZE: w_state_nx = S_COMMIT_A;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state      <= S_IDLE;
      r_edit       <= '0;
      r_alarm      <= '0;
      r_cnt        <= '0;
      r_alarm_on_n <= STROBE_OFF;
      r_stop_n     <= STROBE_OFF;
    end else begin
      r_state      <= w_state_nx;
      r_edit       <= w_edit_nx;
      r_alarm      <= w_alarm_nx;
      r_cnt        <= w_cnt_nx;
      r_alarm_on_n <= w_alarm_on_nx;
      r_stop_n     <= w_stop_nx;
    end
  end

  assign {set_h1_o, set_h2_o, set_m1_o, set_m2_o} = r_edit;
  assign load_time_n_o  = (r_state != S_COMMIT_T);
  assign load_alarm_n_o = (r_state != S_COMMIT_A);
  assign stop_alarm_n_o = r_stop_n;
  assign alarm_on_n_o   = r_alarm_on_n;
  assign field_o        = w_is_hr ? FLD_HR : w_is_min ? FLD_MIN : FLD_NONE;
  assign editing_o      = (field_o != FLD_NONE);

endmodule

// File: tb/tb_clock_set_controller.sv
// Scoreboarded bench: strobe events expected by the stimulus are queued and
// matched by a negedge monitor; level outputs are checked inline.
module tb_clock_set_controller;

  localparam int K_LT = 0, K_LA = 1, K_STOP = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic mode = 1'b0, inc = 1'b0, ok = 1'b0, alarm = 1'b0;
  logic [1:0] ch1 = '0;
  logic [3:0] ch2 = '0, cm1 = '0, cm2 = '0;
  logic [1:0] sh1, field;
  logic [3:0] sh2, sm1, sm2;
  logic lt, la, stop, aon, editing;
  logic [13:0] w_set;

  typedef struct { int kind; logic [13:0] val; } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  clock_set_controller #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .mode_btn_i(mode), .inc_btn_i(inc), .ok_btn_i(ok),
    .cur_h1_i(ch1), .cur_h2_i(ch2), .cur_m1_i(cm1), .cur_m2_i(cm2), .alarm_i(alarm),
    .set_h1_o(sh1), .set_h2_o(sh2), .set_m1_o(sm1), .set_m2_o(sm2),
    .load_time_n_o(lt), .load_alarm_n_o(la), .stop_alarm_n_o(stop), .alarm_on_n_o(aon),
    .editing_o(editing), .field_o(field)
  );

  assign w_set = {sh1, sh2, sm1, sm2};

  function automatic logic [13:0] t(input int hh, input int mm);
    return {2'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic press(input logic m, input logic i, input logic o);
    @(posedge clk); #1;
    mode = m; inc = i; ok = o;
    @(posedge clk); #1;
    mode = 1'b0; inc = 1'b0; ok = 1'b0;
  endtask

  task automatic press_n(input logic m, input logic i, input int n);
    for (int k = 0; k < n; k++) press(m, i, 1'b0);
  endtask

  task automatic push(input int k, input logic [13:0] v);
    exp_t e;
    e.kind = k; e.val = v;
    sb.push_back(e);
  endtask

  task automatic set_cur(input int hh, input int mm);
    {ch1, ch2, cm1, cm2} = t(hh, mm);
  endtask

  // Every low strobe cycle must match exactly one queued expectation.
  always @(negedge clk) begin
    if (rst_n && (!lt || !la || !stop)) begin
      exp_t e;
      int ak;
      ak = !lt ? K_LT : !la ? K_LA : K_STOP;
      n_chk++;
      if (!lt && !la) begin
        n_err++;
        $display("FAIL both_loads: got lt=%0b la=%0b expected one high", lt, la);
      end else if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: got kind %0d set %h expected none", ak, w_set);
      end else begin
        e = sb.pop_front();
        if (e.kind != ak || (ak != K_STOP && e.val !== w_set)) begin
          n_err++;
          $display("FAIL strobe: got kind %0d set %h expected kind %0d set %h",
                   ak, w_set, e.kind, e.val);
        end
      end
    end
  end

  initial begin
    set_cur(13, 45);
    repeat (2) @(posedge clk); #1;
    chk("rst_set", 32'(w_set), 0);
    chk("rst_strobes", {28'd0, lt, la, stop, aon}, 32'hF);
    chk("rst_field", {29'd0, editing, field}, 0);
    rst_n = 1'b1;

    // async reset in the middle of a time edit
    press(1, 0, 0);
    chk("thr_field", 32'(field), 1);
    chk("thr_set", 32'(w_set), 32'(t(13, 45)));
    press(1, 0, 0);
    chk("tmin_field", 32'(field), 2);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_set", 32'(w_set), 0);
    chk("midrst_out", {25'd0, lt, la, stop, aon, editing, field}, 32'b1111000);
    @(posedge clk); #1 rst_n = 1'b1;

    // time set with hour and minute wrap
    press(1, 0, 0);
    press_n(0, 1, 11);
    chk("t_hr_wrap", 32'(w_set), 32'(t(0, 45)));
    press(1, 0, 0);
    press_n(0, 1, 15);
    chk("t_min_wrap", 32'(w_set), 32'(t(0, 0)));
    push(K_LT, t(0, 0));
    press(0, 0, 1);
    chk("commit_t_lt", 32'(lt), 0);
    @(posedge clk); #1;
    chk("after_commit_t", {30'd0, lt, editing}, 32'b10);

    // alarm set, then re-entry shows stored alarm
    press_n(1, 0, 3);
    chk("a_hr_init", 32'(w_set), 32'(t(0, 0)));
    chk("a_hr_field", 32'(field), 1);
    press_n(0, 1, 14);
    press(1, 0, 0);
    press_n(0, 1, 16);
    push(K_LA, t(14, 16));
    press(0, 0, 1);
    repeat (2) @(posedge clk); #1;
    press_n(1, 0, 3);
    chk("a_hr_shadow", 32'(w_set), 32'(t(14, 16)));

    // ok+inc at 59: inc dropped; then inc alone wraps minutes only
    press(1, 0, 0);
    press_n(0, 1, 43);
    chk("a_min_59", 32'(w_set), 32'(t(14, 59)));
    push(K_LA, t(14, 59));
    press(0, 1, 1);
    repeat (2) @(posedge clk); #1;
    press_n(1, 0, 4);
    chk("a_min_reentry", 32'(w_set), 32'(t(14, 59)));
    press(0, 1, 0);
    chk("min_wrap", 32'(w_set), 32'(t(14, 0)));
    press(1, 0, 0);
    chk("amin_discard", 32'(editing), 0);

    // timeout after 4 idle cycles, no strobe, set_* keep captured value
    press(1, 0, 0);
    set_cur(7, 30);
    repeat (3) @(posedge clk); #1;
    chk("to_still_edit", 32'(editing), 1);
    @(posedge clk); #1;
    chk("to_idle", 32'(editing), 0);
    chk("to_set", 32'(w_set), 32'(t(13, 45)));

    // idle buttons: arm toggle, stop, priority
    press(0, 1, 0);
    chk("arm_on", 32'(aon), 0);
    press(0, 1, 0);
    chk("arm_off", 32'(aon), 1);
    alarm = 1'b1;
    push(K_STOP, '0);
    press(0, 0, 1);
    chk("stop_low", 32'(stop), 0);
    @(posedge clk); #1;
    chk("stop_one_cycle", 32'(stop), 1);
    alarm = 1'b0;
    press(0, 0, 1);
    press(1, 0, 1);
    chk("ok_over_mode", 32'(editing), 0);
    press(1, 1, 0);
    chk("mode_over_inc", {30'd0, aon, field == 2'd1}, 32'b11);
    press_n(1, 0, 4);
    chk("back_idle", 32'(editing), 0);

    // mode while ringing at 23:58
    set_cur(23, 58);
    alarm = 1'b1;
`ifdef CLOCK_SET_SNOOZE_EN
    push(K_STOP, '0);
    push(K_LA, t(0, 3));
    press(1, 0, 0);
    chk("snz_stop", 32'(stop), 0);
    @(posedge clk); #1;
    chk("snz_load", {18'd0, la, w_set}, {18'd0, 1'b0, t(0, 3)});
    @(posedge clk); #1;
    chk("snz_done", {30'd0, editing, aon}, 32'b01);
    alarm = 1'b0;
`else
    press(1, 0, 0);
    chk("nosnz_field", 32'(field), 1);
    chk("nosnz_set", 32'(w_set), 32'(t(23, 58)));
    alarm = 1'b0;
    press_n(1, 0, 4);
`endif

    repeat (3) @(posedge clk); #1;
    chk("sb_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
